// File: rtl/despreader_if.sv
// rtl/despreader_if.sv - chip-sample, symbol and PN-chip handshake bundle for the despreader
interface despreader_if;
  logic [31:0] i_data_TDATA;
  logic        i_data_TVALID;
  logic        i_data_TREADY;
  logic        i_data_TLAST;
  logic [31:0] o_data_TDATA;
  logic        o_data_TVALID;
  logic        o_data_TREADY;
  logic        o_data_TLAST;
  logic        pnseq_V_V;
  logic        pnseq_V_V_ap_vld;
  logic        pnseq_V_V_ap_ack;
  logic        pnseq_load;
  logic [9:0]  pnseq_len_V;

  // Despreader side
  modport slave (
    input  i_data_TDATA, i_data_TVALID, i_data_TLAST,
    output i_data_TREADY,
    output o_data_TDATA, o_data_TVALID, o_data_TLAST,
    input  o_data_TREADY,
    input  pnseq_V_V, pnseq_V_V_ap_vld, pnseq_len_V,
    output pnseq_V_V_ap_ack, pnseq_load
  );

  // Sample source / symbol sink / LFSR side
  modport master (
    output i_data_TDATA, i_data_TVALID, i_data_TLAST,
    input  i_data_TREADY,
    input  o_data_TDATA, o_data_TVALID, o_data_TLAST,
    output o_data_TREADY,
    output pnseq_V_V, pnseq_V_V_ap_vld, pnseq_len_V,
    input  pnseq_V_V_ap_ack, pnseq_load
  );
endinterface

// File: rtl/despreader.sv
// rtl/despreader.sv - DSSS despreader: integrates len PN-signed SC16 chips into one SC16 symbol
module despreader #(
  parameter int ACC_W     = 26,
  parameter int OUT_SHIFT = 0
) (
  input logic         ap_clk,
  input logic         ap_rst_n,
  despreader_if.slave bus
);

  typedef enum logic [1:0] {LOAD, ACCUM, OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_t state, state_next;

  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] smp_i, smp_q;
  logic signed [ACC_W-1:0] acc_i_next, acc_q_next;
  logic signed [ACC_W-1:0] sh_i, sh_q;
  logic [9:0]  len, cnt;
  logic        last_sticky;
  logic [31:0] out_data;
  logic        out_last;
  logic        accept;
  logic        final_chip;

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return 16'h7fff;
    else if (v < SAT_MIN) return 16'h8000;
    else return v[15:0];
  endfunction

  // Chip datapath: PN chip 1 adds the sample, chip 0 subtracts it, on both rails
  always_comb begin
    smp_i      = ACC_W'($signed(bus.i_data_TDATA[31:16]));
    smp_q      = ACC_W'($signed(bus.i_data_TDATA[15:0]));
    acc_i_next = bus.pnseq_V_V ? (acc_i + smp_i) : (acc_i - smp_i);
    acc_q_next = bus.pnseq_V_V ? (acc_q + smp_q) : (acc_q - smp_q);
    sh_i       = acc_i_next >>> OUT_SHIFT;
    sh_q       = acc_q_next >>> OUT_SHIFT;
    final_chip = (cnt == (len - 10'd1));
    accept     = (state == ACCUM) && bus.pnseq_V_V_ap_vld && bus.i_data_TVALID;
  end

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= LOAD;
    else           state <= state_next;
  end

  // Next-state and handshake outputs; load is held off while reset is asserted
  always_comb begin
    state_next            = state;
    bus.i_data_TREADY     = 1'b0;
    bus.pnseq_V_V_ap_ack  = 1'b0;
    bus.pnseq_load        = 1'b0;
    bus.o_data_TVALID     = 1'b0;
    bus.o_data_TDATA      = out_data;
    bus.o_data_TLAST      = out_last;
    case (state)
      LOAD: begin
        bus.pnseq_load = ap_rst_n;
        state_next     = ACCUM;
      end
      ACCUM: begin
        bus.i_data_TREADY    = bus.pnseq_V_V_ap_vld;
        bus.pnseq_V_V_ap_ack = accept;
        if (accept && final_chip) state_next = OUT;
      end
      OUT: begin
        bus.o_data_TVALID = 1'b1;
        if (bus.o_data_TREADY) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Symbol integration: restart in LOAD, accumulate in ACCUM, capture the word on the final chip
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_i       <= '0;
      acc_q       <= '0;
      cnt         <= '0;
      len         <= 10'd1;
      last_sticky <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          len         <= (bus.pnseq_len_V == 10'd0) ? 10'd1 : bus.pnseq_len_V;
          acc_i       <= '0;
          acc_q       <= '0;
          cnt         <= '0;
          last_sticky <= 1'b0;
        end
        ACCUM: begin
          if (accept) begin
            acc_i       <= acc_i_next;
            acc_q       <= acc_q_next;
            cnt         <= cnt + 10'd1;
            last_sticky <= last_sticky | bus.i_data_TLAST;
            if (final_chip) begin
              out_data <= {sat16(sh_i), sat16(sh_q)};
              out_last <= last_sticky | bus.i_data_TLAST;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_despreader.sv
// tb/tb_despreader.sv - scoreboard testbench for despreader
module tb_despreader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  despreader_if bus();

  despreader #(.ACC_W(26), .OUT_SHIFT(0)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          acks;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;
  int load_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts ack/load pulses and checks every output handshake against the scoreboard
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      ack_cnt  = 0;
      load_cnt = 0;
    end else begin
      if (bus.pnseq_V_V_ap_ack) ack_cnt++;
      if (bus.pnseq_load) load_cnt++;
      if (bus.o_data_TVALID && bus.o_data_TREADY) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got 0x%08h expected no output", bus.o_data_TDATA);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.o_data_TDATA, e.data);
          check("out_last", 32'(bus.o_data_TLAST), 32'(e.last));
          check("ack_count", ack_cnt, e.acks);
          check("load_count", load_cnt, 1);
        end
        ack_cnt  = 0;
        load_cnt = 0;
      end
    end
  end

  // Drives n chips; chip k uses pat[3-k%4] and sample s0 (even k) or s1 (odd k)
  task automatic send_sym(input int n, input logic [3:0] pat, input logic [31:0] s0,
                          input logic [31:0] s1, input int last_idx, input int stall_idx,
                          input logic push, input logic [31:0] exp_d, input logic exp_l);
    logic acc;
    if (push) sb.push_back('{exp_d, exp_l, n});
    for (int k = 0; k < n; k++) begin
      acc = 1'b0;
      @(negedge clk);
      if (k == stall_idx) begin
        bus.pnseq_V_V_ap_vld = 1'b0;
        bus.i_data_TVALID    = 1'b1;
        bus.i_data_TDATA     = (k % 2 == 0) ? s0 : s1;
        for (int j = 0; j < 3; j++) begin
          #1;
          check("stall_tready", 32'(bus.i_data_TREADY), 32'd0);
          @(negedge clk);
        end
      end
      bus.i_data_TDATA     = (k % 2 == 0) ? s0 : s1;
      bus.pnseq_V_V        = pat[3 - (k % 4)];
      bus.i_data_TLAST     = (k == last_idx);
      bus.i_data_TVALID    = 1'b1;
      bus.pnseq_V_V_ap_vld = 1'b1;
      for (int t = 0; t < 20 && !acc; t++) begin
        #1;
        if (bus.i_data_TREADY) begin
          acc = 1'b1;
          @(posedge clk);
        end else begin
          @(negedge clk);
        end
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL chip_accept: got no accept expected accept of chip %0d", k);
      end
    end
    @(negedge clk);
    bus.i_data_TVALID    = 1'b0;
    bus.pnseq_V_V_ap_vld = 1'b0;
    bus.i_data_TLAST     = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL output_timeout: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tready"}, 32'(bus.i_data_TREADY), 32'd0);
    check({tag, "_tvalid"}, 32'(bus.o_data_TVALID), 32'd0);
    check({tag, "_tdata"}, bus.o_data_TDATA, 32'd0);
    check({tag, "_tlast"}, 32'(bus.o_data_TLAST), 32'd0);
    check({tag, "_ack"}, 32'(bus.pnseq_V_V_ap_ack), 32'd0);
    check({tag, "_load"}, 32'(bus.pnseq_load), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_data_TDATA     = 32'd0;
    bus.i_data_TVALID    = 1'b1;
    bus.i_data_TLAST     = 1'b0;
    bus.o_data_TREADY    = 1'b1;
    bus.pnseq_V_V        = 1'b1;
    bus.pnseq_V_V_ap_vld = 1'b1;
    bus.pnseq_len_V      = 10'd4;

    // Reset state
    #2;
    check_zero_outputs("reset");
    bus.i_data_TVALID    = 1'b0;
    bus.pnseq_V_V_ap_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // All-ones chips, (100,-50) x4
    send_sym(4, 4'b1111, 32'h0064FFCE, 32'h0064FFCE, -1, -1, 1'b1, 32'h0190FF38, 1'b0);
    wait_idle();

    // Alternating chips cancel a constant sample
    send_sym(4, 4'b1010, 32'h03E803E8, 32'h03E803E8, -1, -1, 1'b1, 32'h00000000, 1'b0);
    wait_idle();

    // Alternating chips against alternating samples -> (4000,-28)
    send_sym(4, 4'b1010, 32'h03E8FFF9, 32'hFC180007, -1, -1, 1'b1, 32'h0FA0FFE4, 1'b0);
    wait_idle();

    // Same symbol with PN valid dropped for 3 cycles before chip 3
    send_sym(4, 4'b1010, 32'h03E8FFF9, 32'hFC180007, -1, 2, 1'b1, 32'h0FA0FFE4, 1'b0);
    wait_idle();

    // Input TLAST on chip 2 marks this symbol only
    send_sym(4, 4'b1111, 32'h0064FFCE, 32'h0064FFCE, 1, -1, 1'b1, 32'h0190FF38, 1'b1);
    send_sym(4, 4'b1111, 32'h0064FFCE, 32'h0064FFCE, -1, -1, 1'b1, 32'h0190FF38, 1'b0);
    wait_idle();

    // Output backpressure for 5 cycles
    bus.o_data_TREADY = 1'b0;
    send_sym(4, 4'b1111, 32'h0064FFCE, 32'h0064FFCE, -1, -1, 1'b1, 32'h0190FF38, 1'b0);
    bus.i_data_TVALID    = 1'b1;
    bus.pnseq_V_V_ap_vld = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      check("bp_tvalid", 32'(bus.o_data_TVALID), 32'd1);
      check("bp_tdata", bus.o_data_TDATA, 32'h0190FF38);
      check("bp_tready", 32'(bus.i_data_TREADY), 32'd0);
      check("bp_ack", 32'(bus.pnseq_V_V_ap_ack), 32'd0);
    end
    @(negedge clk);
    bus.i_data_TVALID    = 1'b0;
    bus.pnseq_V_V_ap_vld = 1'b0;
    bus.o_data_TREADY    = 1'b1;
    wait_idle();

    // Length 0 behaves as 1: each sample is emitted as +/- sample
    bus.pnseq_len_V = 10'd0;
    send_sym(1, 4'b1111, 32'h0005FFFD, 32'h0005FFFD, -1, -1, 1'b1, 32'h0005FFFD, 1'b0);
    send_sym(1, 4'b0000, 32'h0005FFFD, 32'h0005FFFD, -1, -1, 1'b1, 32'hFFFB0003, 1'b0);
    wait_idle();

    // Saturation with 1023 chips
    bus.pnseq_len_V = 10'd1023;
    send_sym(1023, 4'b1111, 32'h7FFF8000, 32'h7FFF8000, -1, -1, 1'b1, 32'h7FFF8000, 1'b0);
    wait_idle();
    send_sym(1023, 4'b0000, 32'h80000000, 32'h80000000, -1, -1, 1'b1, 32'h7FFF0000, 1'b0);
    wait_idle();

    // Reset after 2 of 4 chips discards the partial symbol
    bus.pnseq_len_V = 10'd4;
    send_sym(2, 4'b1111, 32'h0064FFCE, 32'h0064FFCE, -1, -1, 1'b0, 32'h0, 1'b0);
    rst_n                = 1'b0;
    bus.i_data_TVALID    = 1'b1;
    bus.pnseq_V_V_ap_vld = 1'b1;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    bus.i_data_TVALID    = 1'b0;
    bus.pnseq_V_V_ap_vld = 1'b0;
    rst_n                = 1'b1;
    send_sym(4, 4'b1111, 32'h0064FFCE, 32'h0064FFCE, -1, -1, 1'b1, 32'h0190FF38, 1'b0);
    wait_idle();

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
